// File: rtl/peripheral_ahb2apb_pkg.sv
// peripheral_ahb2apb_pkg: shared AHB codes and bridge state encoding
package peripheral_ahb2apb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'd0, HSIZE_HWORD = 3'd1, HSIZE_WORD = 3'd2, HSIZE_DWORD = 3'd3;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/peripheral_ahb2apb_strb.sv
// peripheral_ahb2apb_strb: byte strobes and oversize flag from HSIZE and low address bits
module peripheral_ahb2apb_strb
  import peripheral_ahb2apb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                hsize,
  input  logic [$clog2(XLEN/8)-1:0] addr,
  input  logic                      hwrite,
  output logic [XLEN/8-1:0]         strb,
  output logic                      size_err
);
  localparam int SW = XLEN / 8;
  localparam int AW = $clog2(SW);
  int nb, off;
  always_comb begin
    size_err = hsize > 3'(AW);
    nb = 1 << hsize;
    off = int'(addr) & ~(nb - 1);
    strb = (hwrite && !size_err) ? SW'(((1 << nb) - 1) << off) : '0;
  end
endmodule

// File: rtl/peripheral_ahb2apb_bridge.sv
// peripheral_ahb2apb_bridge: AHB-Lite slave to APB4 master, one APB transaction per AHB beat
module peripheral_ahb2apb_bridge
  import peripheral_ahb2apb_pkg::*;
#(
  parameter int PLEN = 8,
  parameter int XLEN = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [PLEN-1:0]   HADDR,
  input  logic [XLEN-1:0]   HWDATA,
  output logic [XLEN-1:0]   HRDATA,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [1:0]        HTRANS,
  input  logic              HMASTLOCK,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [PLEN-1:0]   PADDR,
  output logic              PWRITE,
  output logic [XLEN-1:0]   PWDATA,
  output logic [XLEN/8-1:0] PSTRB,
  output logic [2:0]        PPROT,
  input  logic [XLEN-1:0]   PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  localparam int AW = $clog2(XLEN / 8);
  state_t state, acc_state;
  logic rdy, done, acc, size_err, unused;
  logic [XLEN/8-1:0] strb;
  logic [XLEN-1:0] hrdata_q;
  peripheral_ahb2apb_strb #(.XLEN(XLEN)) u_strb (
    .hsize(HSIZE), .addr(HADDR[AW-1:0]), .hwrite(HWRITE), .strb(strb), .size_err(size_err)
  );
  assign done = state == ST_ACCESS && PREADY && !PSLVERR;
  assign HREADYOUT = rdy | done;
  assign HRDATA = done ? PRDATA : hrdata_q;
  assign acc = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign acc_state = !acc ? ST_IDLE : size_err ? ST_ERR1 : HWRITE ? ST_WDATA : ST_SETUP;
  assign unused = ^{HBURST, HMASTLOCK, HPROT[3:2], HTRANS[0]};
  // Whenever the bridge is ready (IDLE, ERR2, completing ACCESS) the next state comes from the address phase
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      PSEL <= 1'b0;
      PENABLE <= 1'b0;
      PADDR <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB <= '0;
      PPROT <= '0;
      rdy <= 1'b1;
      HRESP <= HRESP_OKAY;
      hrdata_q <= '0;
    end else begin
      if (done) hrdata_q <= PRDATA;
      if (acc) begin
        PADDR <= HADDR;
        PWRITE <= HWRITE;
        PPROT <= {~HPROT[0], 1'b0, HPROT[1]};
        PSTRB <= strb;
      end
      if (HREADYOUT) begin
        state <= acc_state;
        rdy <= acc_state == ST_IDLE;
        PSEL <= acc_state == ST_SETUP;
        PENABLE <= 1'b0;
        HRESP <= acc_state == ST_ERR1 ? HRESP_ERROR : HRESP_OKAY;
      end else begin
        case (state)
          ST_WDATA: begin
            PWDATA <= HWDATA;
            PSEL <= 1'b1;
            state <= ST_SETUP;
          end
          ST_SETUP: begin
            PENABLE <= 1'b1;
            state <= ST_ACCESS;
          end
          ST_ACCESS: if (PREADY) begin
            PSEL <= 1'b0;
            PENABLE <= 1'b0;
            HRESP <= HRESP_ERROR;
            state <= ST_ERR1;
          end
          ST_ERR1: begin
            rdy <= 1'b1;
            state <= ST_ERR2;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_peripheral_ahb2apb_bridge.sv
// tb_peripheral_ahb2apb_bridge: directed checks of the AHB-to-APB bridge
module tb_peripheral_ahb2apb_bridge;
  logic HCLK = 1'b0;
  logic HRESETn, HSEL, HWRITE, HMASTLOCK, HREADY, HREADYOUT, HRESP;
  logic PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0] HADDR, PADDR;
  logic [31:0] HWDATA, HRDATA, PWDATA, PRDATA;
  logic [2:0] HSIZE, HBURST, PPROT;
  logic [3:0] HPROT, PSTRB;
  logic [1:0] HTRANS;
  int vectors = 0, errs = 0;
  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;
  peripheral_ahb2apb_bridge #(.PLEN(8), .XLEN(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge HCLK);
    #1;
  endtask
  task automatic smp;
    @(negedge HCLK);
  endtask
  task automatic addr_ph(input logic w, input logic [7:0] a, input logic [2:0] sz, input logic [3:0] prot);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HWRITE = w;
    HADDR = a;
    HSIZE = sz;
    HPROT = prot;
  endtask
  task automatic idle_bus;
    HSEL = 1'b0;
    HTRANS = 2'b00;
  endtask
  initial begin
    HRESETn = 1'b0; idle_bus; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2; HPROT = '0;
    HBURST = '0; HMASTLOCK = 1'b0; HWDATA = '0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    step; step;
    HRESETn = 1'b1;
    smp;
    chk("rst_psel", 32'(PSEL), 0); chk("rst_penable", 32'(PENABLE), 0);
    chk("rst_paddr", 32'(PADDR), 0); chk("rst_pwrite", 32'(PWRITE), 0);
    chk("rst_pwdata", PWDATA, 0); chk("rst_pstrb", 32'(PSTRB), 0);
    chk("rst_pprot", 32'(PPROT), 0); chk("rst_hreadyout", 32'(HREADYOUT), 1);
    chk("rst_hresp", 32'(HRESP), 0); chk("rst_hrdata", HRDATA, 0);
    step;
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 8'h10;
    smp; chk("busy_rdy", 32'(HREADYOUT), 1); chk("busy_resp", 32'(HRESP), 0);
    step;
    smp; chk("busy_psel", 32'(PSEL), 0); chk("busy_rdy2", 32'(HREADYOUT), 1);
    step;
    addr_ph(1'b0, 8'h10, 3'd2, 4'b0011); HBURST = 3'd3; HMASTLOCK = 1'b1; PRDATA = 32'hDEADBEEF;
    smp; chk("rd_addr_rdy", 32'(HREADYOUT), 1);
    step;
    idle_bus;
    smp;
    chk("rd_setup_psel", 32'(PSEL), 1); chk("rd_setup_pen", 32'(PENABLE), 0);
    chk("rd_setup_rdy", 32'(HREADYOUT), 0); chk("rd_paddr", 32'(PADDR), 32'h10);
    chk("rd_pprot", 32'(PPROT), 1); chk("rd_pwrite", 32'(PWRITE), 0); chk("rd_pstrb", 32'(PSTRB), 0);
    step;
    smp;
    chk("rd_acc_psel", 32'(PSEL), 1); chk("rd_acc_pen", 32'(PENABLE), 1);
    chk("rd_acc_rdy", 32'(HREADYOUT), 1); chk("rd_hrdata", HRDATA, 32'hDEADBEEF); chk("rd_hresp", 32'(HRESP), 0);
    step;
    PRDATA = 32'h12345678; HBURST = '0; HMASTLOCK = 1'b0;
    smp; chk("rd_end_psel", 32'(PSEL), 0); chk("rd_end_pen", 32'(PENABLE), 0); chk("rd_hold", HRDATA, 32'hDEADBEEF);
    step;
    addr_ph(1'b1, 8'h23, 3'd0, 4'b0001);
    smp; step;
    idle_bus; HWDATA = 32'hAA000000;
    smp;
    chk("wr_wdata_rdy", 32'(HREADYOUT), 0); chk("wr_wdata_psel", 32'(PSEL), 0);
    chk("wr_paddr", 32'(PADDR), 32'h23); chk("wr_pstrb", 32'(PSTRB), 32'h8);
    chk("wr_pwrite", 32'(PWRITE), 1); chk("wr_pprot", 32'(PPROT), 0);
    step;
    HWDATA = 32'h55555555;
    smp;
    chk("wr_setup_psel", 32'(PSEL), 1); chk("wr_setup_pen", 32'(PENABLE), 0);
    chk("wr_pwdata", PWDATA, 32'hAA000000); chk("wr_setup_rdy", 32'(HREADYOUT), 0);
    step;
    addr_ph(1'b0, 8'h44, 3'd2, 4'b0000);
    smp; chk("wr_acc_pen", 32'(PENABLE), 1); chk("wr_acc_rdy", 32'(HREADYOUT), 1); chk("wr_acc_pwdata", PWDATA, 32'hAA000000);
    step;
    idle_bus; PREADY = 1'b0;
    smp;
    chk("b2b_psel", 32'(PSEL), 1); chk("b2b_pen", 32'(PENABLE), 0); chk("b2b_paddr", 32'(PADDR), 32'h44);
    chk("b2b_pwrite", 32'(PWRITE), 0); chk("b2b_pstrb", 32'(PSTRB), 0); chk("b2b_pprot", 32'(PPROT), 4);
    step;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("stall_psel", 32'(PSEL), 1); chk("stall_pen", 32'(PENABLE), 1);
      chk("stall_paddr", 32'(PADDR), 32'h44); chk("stall_rdy", 32'(HREADYOUT), 0);
      step;
    end
    PREADY = 1'b1; PRDATA = 32'hCAFEF00D;
    smp; chk("stall_done_rdy", 32'(HREADYOUT), 1); chk("stall_hrdata", HRDATA, 32'hCAFEF00D);
    step;
    smp; chk("stall_end_psel", 32'(PSEL), 0);
    step;
    addr_ph(1'b1, 8'h08, 3'd2, 4'b0000);
    smp; step;
    idle_bus; HWDATA = 32'h11223344;
    smp; chk("err_pstrb", 32'(PSTRB), 32'hF);
    step;
    smp; step;
    PSLVERR = 1'b1; PRDATA = 32'hFFFFFFFF;
    smp; chk("err_acc_rdy", 32'(HREADYOUT), 0); chk("err_acc_resp", 32'(HRESP), 0); chk("err_acc_hrdata", HRDATA, 32'hCAFEF00D);
    step;
    PSLVERR = 1'b0;
    smp;
    chk("err1_resp", 32'(HRESP), 1); chk("err1_rdy", 32'(HREADYOUT), 0);
    chk("err1_psel", 32'(PSEL), 0); chk("err1_pen", 32'(PENABLE), 0);
    step;
    smp; chk("err2_resp", 32'(HRESP), 1); chk("err2_rdy", 32'(HREADYOUT), 1);
    step;
    smp; chk("err_idle_resp", 32'(HRESP), 0); chk("err_idle_rdy", 32'(HREADYOUT), 1); chk("err_hrdata_hold", HRDATA, 32'hCAFEF00D);
    step;
    addr_ph(1'b1, 8'h00, 3'd3, 4'b0000);
    smp; step;
    idle_bus;
    smp; chk("sz_err1_psel", 32'(PSEL), 0); chk("sz_err1_resp", 32'(HRESP), 1); chk("sz_err1_rdy", 32'(HREADYOUT), 0);
    step;
    addr_ph(1'b1, 8'h32, 3'd1, 4'b0000);
    smp; chk("sz_err2_resp", 32'(HRESP), 1); chk("sz_err2_rdy", 32'(HREADYOUT), 1); chk("sz_err2_psel", 32'(PSEL), 0);
    step;
    idle_bus; HWDATA = 32'hBEEF0000;
    smp;
    chk("hw_resp", 32'(HRESP), 0); chk("hw_rdy", 32'(HREADYOUT), 0);
    chk("hw_pstrb", 32'(PSTRB), 32'hC); chk("hw_paddr", 32'(PADDR), 32'h32);
    step;
    smp; chk("hw_pwdata", PWDATA, 32'hBEEF0000); chk("hw_setup_psel", 32'(PSEL), 1);
    step;
    smp; chk("hw_acc_rdy", 32'(HREADYOUT), 1);
    step;
    addr_ph(1'b0, 8'h50, 3'd2, 4'b0000); PREADY = 1'b0;
    smp; step;
    idle_bus;
    smp; step;
    smp; chk("rst_pre_pen", 32'(PENABLE), 1); chk("rst_pre_rdy", 32'(HREADYOUT), 0);
    HRESETn = 1'b0;
    step;
    HRESETn = 1'b1;
    smp;
    chk("rst_mid_psel", 32'(PSEL), 0); chk("rst_mid_pen", 32'(PENABLE), 0);
    chk("rst_mid_rdy", 32'(HREADYOUT), 1); chk("rst_mid_resp", 32'(HRESP), 0); chk("rst_mid_hrdata", HRDATA, 0);
    step;
    addr_ph(1'b0, 8'h60, 3'd2, 4'b0000); PREADY = 1'b1; PRDATA = 32'h0BADCAFE;
    smp; step;
    idle_bus;
    smp; chk("ar_psel", 32'(PSEL), 1); chk("ar_paddr", 32'(PADDR), 32'h60);
    step;
    smp; chk("ar_rdy", 32'(HREADYOUT), 1); chk("ar_hrdata", HRDATA, 32'h0BADCAFE);
    step;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
